// File: rtl/flash_boot_loader.sv
// Boot-time copy engine: streams halfword pairs from the flash driver's continuous-read
// port, packs them little-endian into 32-bit words and pushes them into RAM.
module flash_boot_loader #(
   parameter int FLASH_ADDR_SIZE = 22,
   parameter int RAM_ADDR_SIZE   = 20,
   parameter int COUNT_SIZE      = 20,
   parameter int ACCESS_CYCLES   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [FLASH_ADDR_SIZE-1:0] src_addr,
   input  logic [RAM_ADDR_SIZE-1:0]   dst_addr,
   input  logic [COUNT_SIZE-1:0]      count,
   output logic                       busy,
   output logic                       done,
   output logic                       flash_enable,
   output logic                       flash_enable_read,
   output logic [FLASH_ADDR_SIZE-1:0] flash_addr,
   input  logic [15:0]                flash_data_out,
   input  logic                       flash_busy,
   output logic [RAM_ADDR_SIZE-1:0]   ram_addr,
   output logic [31:0]                ram_data,
   output logic                       ram_we,
   input  logic                       ram_ready
);

   // RAM write port handshake: ram_we is valid, ram_ready is accept; a word transfers on a
   // cycle where both are high, and ram_addr/ram_data hold steady while ram_we waits on ram_ready.

   localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(ACCESS_CYCLES - 1);
   localparam logic [CW-1:0] OPEN_LAST = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      OPEN,
      WAIT_RDY,
      SETTLE_LO,
      SETTLE_HI,
      DRAIN,
      FINISH
   } state_t;

   state_t                     state, state_d;
   logic [CW-1:0]              cnt, cnt_d;
   logic [15:0]                lo, lo_d;
   logic [15:0]                hi, hi_d;
   logic                       hi_held, hi_held_d;
   logic [RAM_ADDR_SIZE-1:0]   dst_cur, dst_cur_d;
   logic [COUNT_SIZE-1:0]      remaining, remaining_d;

   logic                       busy_d, done_d;
   logic                       flash_enable_d, flash_enable_read_d;
   logic [FLASH_ADDR_SIZE-1:0] flash_addr_d;
   logic [RAM_ADDR_SIZE-1:0]   ram_addr_d;
   logic [31:0]                ram_data_d;
   logic                       ram_we_d;
   logic [15:0]                hi_word;
   logic                       out_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         cnt               <= '0;
         lo                <= '0;
         hi                <= '0;
         hi_held           <= 1'b0;
         dst_cur           <= '0;
         remaining         <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         flash_enable      <= 1'b0;
         flash_enable_read <= 1'b0;
         flash_addr        <= '0;
         ram_addr          <= '0;
         ram_data          <= '0;
         ram_we            <= 1'b0;
      end else begin
         state             <= state_d;
         cnt               <= cnt_d;
         lo                <= lo_d;
         hi                <= hi_d;
         hi_held           <= hi_held_d;
         dst_cur           <= dst_cur_d;
         remaining         <= remaining_d;
         busy              <= busy_d;
         done              <= done_d;
         flash_enable      <= flash_enable_d;
         flash_enable_read <= flash_enable_read_d;
         flash_addr        <= flash_addr_d;
         ram_addr          <= ram_addr_d;
         ram_data          <= ram_data_d;
         ram_we            <= ram_we_d;
      end
   end

   always_comb begin
      state_d             = state;
      cnt_d               = cnt;
      lo_d                = lo;
      hi_d                = hi;
      hi_held_d           = hi_held;
      dst_cur_d           = dst_cur;
      remaining_d         = remaining;
      flash_enable_d      = flash_enable;
      flash_enable_read_d = flash_enable_read;
      flash_addr_d        = flash_addr;
      ram_addr_d          = ram_addr;
      ram_data_d          = ram_data;
      ram_we_d            = ram_we;
      hi_word             = hi_held ? hi : flash_data_out;
      out_free            = !ram_we || ram_ready;

      if (ram_we && ram_ready) begin
         ram_we_d = 1'b0;
      end

      case (state)
         IDLE: begin
            if (start) begin
               dst_cur_d   = dst_addr;
               remaining_d = count;
               cnt_d       = '0;
               hi_held_d   = 1'b0;
               if (count == '0) begin
                  state_d = FINISH;
               end else begin
                  flash_enable_d      = 1'b1;
                  flash_enable_read_d = 1'b1;
                  flash_addr_d        = src_addr;
                  state_d             = OPEN;
               end
            end
         end
         OPEN: begin
            if (cnt == OPEN_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_RDY;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         WAIT_RDY: begin
            if (!flash_busy) begin
               cnt_d   = '0;
               state_d = SETTLE_LO;
            end
         end
         SETTLE_LO: begin
            if (cnt == CNT_LAST) begin
               lo_d         = flash_data_out;
               flash_addr_d = flash_addr + FLASH_ADDR_SIZE'(1);
               cnt_d        = '0;
               state_d      = SETTLE_HI;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         SETTLE_HI: begin
            if (cnt != CNT_LAST) begin
               cnt_d = cnt + CW'(1);
            end else if (out_free) begin
               ram_data_d   = {hi_word, lo};
               ram_we_d     = 1'b1;
               ram_addr_d   = dst_cur;
               dst_cur_d    = dst_cur + RAM_ADDR_SIZE'(1);
               remaining_d  = remaining - COUNT_SIZE'(1);
               flash_addr_d = flash_addr + FLASH_ADDR_SIZE'(1);
               hi_held_d    = 1'b0;
               cnt_d        = '0;
               state_d      = (remaining == COUNT_SIZE'(1)) ? DRAIN : SETTLE_LO;
            end else if (!hi_held) begin
               // Output still occupied: keep the high halfword so the stall never re-reads flash.
               hi_d      = flash_data_out;
               hi_held_d = 1'b1;
            end
         end
         DRAIN: begin
            if (ram_we && ram_ready) begin
               flash_enable_d      = 1'b0;
               flash_enable_read_d = 1'b0;
               state_d             = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // busy/done are registered from the next state so they line up with the state itself.
      busy_d = (state_d != IDLE) && (state_d != FINISH);
      done_d = (state_d == FINISH);
   end

endmodule
